// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction prefetch stage: default geometry,
// the FIFO entry layout and the sequential PC increment.
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int FETCH_DW    = 32;  // default instruction width
  localparam int FETCH_AW    = 32;  // default address width
  localparam int FETCH_DEPTH = 4;   // default FIFO depth == fetch credit window
  localparam int PC_STEP     = 4;   // one word-aligned instruction

  // One buffered instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [FETCH_DW-1:0] instr;
    logic [FETCH_AW-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Shift-register FIFO. Entry 0 is always the head, so the head outputs come
// straight from flops. Flush has priority over push and pop. The producer must
// never push into a full FIFO unless it pops in the same cycle.
//
// Ports
//   clk          clock
//   rst          asynchronous reset, active low
//   i_push       write i_push_data at the tail
//   i_push_data  entry to write
//   i_pop        remove the head (ignored when empty)
//   i_flush      discard every entry
//   o_count      number of valid entries
//   o_head_valid registered "FIFO not empty"
//   o_head       registered head entry
// -----------------------------------------------------------------------------
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = FETCH_DEPTH,
  parameter type entry_t = fetch_entry_t,
  localparam int CW      = $clog2(DEPTH + 1),
  localparam int IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  entry_t        i_push_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic [CW-1:0] o_count,
  output logic          o_head_valid,
  output entry_t        o_head
);

  entry_t        r_mem [DEPTH];
  entry_t        w_mem_nxt [DEPTH];
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic [CW-1:0] w_wr_slot;
  logic          r_valid;
  logic          w_pop;

  assign w_pop     = i_pop && (r_count != '0);
  // After a same-cycle pop, the tail slot has moved down by one.
  assign w_wr_slot = r_count - CW'(w_pop);

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    w_mem_nxt   = r_mem;
    w_count_nxt = r_count;
    if (i_flush) begin
      w_count_nxt = '0;
    end else begin
      if (w_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          w_mem_nxt[i] = r_mem[i+1];
        end
      end
      if (i_push) begin
        w_mem_nxt[IW'(w_wr_slot)] = i_push_data;
      end
      w_count_nxt = r_count - CW'(w_pop) + CW'(i_push);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the storage is reset (unlike a RAM-style FIFO) because entry 0
      // drives the head outputs directly and they must read zero in reset.
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      r_mem   <= w_mem_nxt;
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != '0);
    end
  end

  assign o_count      = r_count;
  assign o_head_valid = r_valid;
  assign o_head       = r_mem[0];

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Instruction prefetch stage. Issues sequential word-aligned fetch requests,
// buffers returned instructions with their PCs and hands them to decode. A
// redirect flushes the buffer, marks all outstanding responses as stale and
// restarts fetching at the new PC.
//
// Credit: a request is only issued while (in-flight + buffered) < DEPTH, so
// every outstanding response already owns a FIFO slot.
//
// Ports
//   clk, rst                   clock, asynchronous active-low reset
//   imem_req_valid/ready/addr  fetch request channel
//   imem_rsp_valid/rdata       in-order fetch responses
//   redirect, redirect_pc      one-cycle branch/jump redirect
//   instr_valid/ready          decode handshake
//   instr, instr_pc            head instruction and its PC
// -----------------------------------------------------------------------------
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int            DW       = FETCH_DW,
  parameter int            AW       = FETCH_AW,
  parameter int            DEPTH    = FETCH_DEPTH,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req_valid,
  input  logic          imem_req_ready,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_rsp_valid,
  input  logic [DW-1:0] imem_rdata,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] instr_pc
);

  localparam int CW  = $clog2(DEPTH + 1);
  // Stale responses can still be pending when a new full window is issued
  // and redirected again, so the discard counter gets headroom over DEPTH.
  localparam int DCW = $clog2(2 * DEPTH + 1);

  typedef struct packed {
    logic [DW-1:0] instr;
    logic [AW-1:0] pc;
  } entry_t;

  logic [AW-1:0]  r_fetch_pc;
  logic [AW-1:0]  r_rsp_pc;
  logic [CW-1:0]  r_in_flight;
  logic [DCW-1:0] r_discard;

  logic [CW-1:0]  w_count;
  logic [CW:0]    w_credit_used;
  logic [AW-1:0]  w_redirect_pc;
  logic           w_accept;
  logic           w_drop;
  logic           w_keep;
  logic           w_pop;
  entry_t         w_push_data;
  entry_t         w_head;

  assign w_redirect_pc = {redirect_pc[AW-1:2], 2'b00};
  assign w_credit_used = {1'b0, r_in_flight} + {1'b0, w_count};

  // Qualified with rst: with all counters at zero the credit check alone
  // would present a request while reset is held.
  assign imem_req_valid = rst && !redirect && (w_credit_used < (CW+1)'(DEPTH));
  assign imem_addr      = r_fetch_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;

  // Responses are in order, so the first r_discard of them are the stale ones.
  assign w_drop = (r_discard != '0);
  assign w_keep = imem_rsp_valid && !w_drop && !redirect;
  assign w_pop  = instr_valid && instr_ready && !redirect;

  assign w_push_data = '{instr: imem_rdata, pc: r_rsp_pc};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc  <= RESET_PC;
      r_rsp_pc    <= RESET_PC;
      r_in_flight <= '0;
      r_discard   <= '0;
    end else if (redirect) begin
      // A response landing in the redirect cycle is one of the stale ones
      // and is dropped here, so it does not join the discard count.
      r_fetch_pc  <= w_redirect_pc;
      r_rsp_pc    <= w_redirect_pc;
      r_in_flight <= '0;
      r_discard   <= r_discard + DCW'(r_in_flight) - DCW'(imem_rsp_valid);
    end else begin
      if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + AW'(PC_STEP);
      end
      if (w_keep) begin
        r_rsp_pc <= r_rsp_pc + AW'(PC_STEP);
      end
      r_in_flight <= r_in_flight + CW'(w_accept) - CW'(w_keep);
      if (imem_rsp_valid && w_drop) begin
        r_discard <= r_discard - DCW'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_keep),
    .i_push_data  (w_push_data),
    .i_pop        (w_pop),
    .i_flush      (redirect),
    .o_count      (w_count),
    .o_head_valid (instr_valid),
    .o_head       (w_head)
  );

  assign instr    = w_head.instr;
  assign instr_pc = w_head.pc;

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
// Bench for fetch_queue. A memory model answers each accepted request with
// addr + 0x100 after a programmable latency. A stream-level model tracks the
// PCs decode must see, the number of requests owed credit since the last
// redirect and which responses are stale, and is compared against the DUT on
// every cycle. Directed sections pin specific cycles with literal values.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] DATA_OFS = 32'h100;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rdata     (imem_rdata),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Memory model: in-order responses, data = addr + 0x100, latency >= 1.
  // Each request carries the epoch it was issued in so the model can tell
  // stale responses apart.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] addr;
    int          due;
    int          ep;
  } mreq_t;

  mreq_t mem_q[$];
  int    cyc     = 0;
  int    mem_lat = 1;
  int    rsp_ep  = 0;
  int    epoch   = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #2;
    if (!rst) begin
      mem_q.delete();
      imem_rsp_valid = 1'b0;
    end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rdata     = mem_q[0].addr + DATA_OFS;
      rsp_ep         = mem_q[0].ep;
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rdata     = 32'hDEAD_BEEF;
    end
  end

  always @(negedge clk) begin
    if (rst && imem_req_valid && imem_req_ready) begin
      mem_q.push_back('{imem_addr, cyc + mem_lat, epoch});
    end
  end

  // ---------------------------------------------------------------------------
  // Stream model, checked every cycle.
  //   m_acc  - requests accepted since the last redirect/reset
  //   m_pop  - instructions consumed since then
  //   m_kept - current-epoch responses delivered since then
  // Outstanding-plus-buffered = m_acc - m_pop; buffered = m_kept - m_pop.
  // ---------------------------------------------------------------------------
  int          m_acc  = 0;
  int          m_pop  = 0;
  int          m_kept = 0;
  logic [31:0] m_req_pc = RESET_PC;
  logic [31:0] m_pc     = RESET_PC;

  always @(negedge clk) begin
    if (!rst) begin
      check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      check("rst_addr", imem_addr, RESET_PC);
      check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
      check("rst_instr", instr, 32'd0);
      check("rst_instr_pc", instr_pc, 32'd0);
      epoch    = epoch + 1;
      m_acc    = 0;
      m_pop    = 0;
      m_kept   = 0;
      m_req_pc = RESET_PC;
      m_pc     = RESET_PC;
    end else begin
      check("req_valid", {31'b0, imem_req_valid},
            {31'b0, (!redirect && (m_acc - m_pop) < DEPTH)});
      if (imem_req_valid) check("req_addr", imem_addr, m_req_pc);
      check("instr_valid", {31'b0, instr_valid}, {31'b0, ((m_kept - m_pop) > 0)});
      if (instr_valid) begin
        check("instr_pc", instr_pc, m_pc);
        check("instr", instr, m_pc + DATA_OFS);
      end
      if (instr_valid && instr_ready && !redirect) begin
        m_pc  = m_pc + 32'd4;
        m_pop = m_pop + 1;
      end
      if (imem_req_valid && imem_req_ready) begin
        m_req_pc = m_req_pc + 32'd4;
        m_acc    = m_acc + 1;
      end
      if (imem_rsp_valid && rsp_ep == epoch && !redirect) m_kept = m_kept + 1;
      if (redirect) begin
        epoch    = epoch + 1;
        m_acc    = 0;
        m_pop    = 0;
        m_kept   = 0;
        m_req_pc = {redirect_pc[31:2], 2'b00};
        m_pc     = {redirect_pc[31:2], 2'b00};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && !instr_valid; i++) @(negedge clk);
  endtask

  int acc_cnt;

  initial begin
    rst            = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rdata     = 32'h0;
    redirect       = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b1;
    repeat (3) next_cycle();

    // --- reset release, 1-cycle memory, decode always ready ----------------
    rst = 1'b1;
    @(negedge clk);
    check("t1_first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("t1_first_addr", imem_addr, 32'h0);
    check("t1_valid_n", {31'b0, instr_valid}, 32'd0);
    @(negedge clk);
    check("t1_valid_n1", {31'b0, instr_valid}, 32'd0);
    @(negedge clk);
    check("t1_valid_n2", {31'b0, instr_valid}, 32'd1);
    check("t1_instr0", instr, 32'h100);
    check("t1_pc0", instr_pc, 32'h0);
    @(negedge clk);
    check("t1_instr1", instr, 32'h104);
    check("t1_pc1", instr_pc, 32'h4);
    @(negedge clk);
    check("t1_instr2", instr, 32'h108);
    check("t1_pc2", instr_pc, 32'h8);
    repeat (4) next_cycle();

    // --- decode stalled: window fills to DEPTH, then drains in order --------
    rst         = 1'b0;
    instr_ready = 1'b0;
    repeat (2) next_cycle();
    rst     = 1'b1;
    acc_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) acc_cnt++;
    end
    check("t2_accepts", acc_cnt, 32'd4);
    check("t2_req_stalled", {31'b0, imem_req_valid}, 32'd0);
    check("t2_full_head_pc", instr_pc, 32'h0);
    next_cycle();
    instr_ready = 1'b1;
    @(negedge clk);
    check("t2_drain_pc0", instr_pc, 32'h0);
    @(negedge clk);
    check("t2_drain_pc4", instr_pc, 32'h4);
    check("t2_resume_valid", {31'b0, imem_req_valid}, 32'd1);
    check("t2_resume_addr", imem_addr, 32'h10);
    @(negedge clk);
    check("t2_drain_pc8", instr_pc, 32'h8);
    @(negedge clk);
    check("t2_drain_pcc", instr_pc, 32'hC);
    @(negedge clk);
    check("t2_next_valid", {31'b0, instr_valid}, 32'd1);
    check("t2_next_pc", instr_pc, 32'h10);
    repeat (3) next_cycle();

    // --- 3-cycle memory, 3 in flight, redirect to 0x203 ---------------------
    rst     = 1'b0;
    mem_lat = 3;
    repeat (2) next_cycle();
    rst = 1'b1;
    repeat (3) next_cycle();
    redirect    = 1'b1;
    redirect_pc = 32'h203;
    @(negedge clk);
    check("t3_no_req_in_redirect", {31'b0, imem_req_valid}, 32'd0);
    next_cycle();
    redirect = 1'b0;
    @(negedge clk);
    check("t3_req_valid_r1", {31'b0, imem_req_valid}, 32'd1);
    check("t3_addr_r1", imem_addr, 32'h200);
    check("t3_valid_r1", {31'b0, instr_valid}, 32'd0);
    wait_valid(20);
    check("t3_new_valid", {31'b0, instr_valid}, 32'd1);
    check("t3_new_pc", instr_pc, 32'h200);
    check("t3_new_instr", instr, 32'h300);

    // --- redirect together with a response and a pop ------------------------
    mem_lat = 1;
    repeat (8) next_cycle();
    redirect    = 1'b1;
    redirect_pc = 32'h400;
    @(negedge clk);
    check("t4_pop_pending", {31'b0, instr_valid}, 32'd1);
    next_cycle();
    redirect = 1'b0;
    @(negedge clk);
    check("t4_valid_r1", {31'b0, instr_valid}, 32'd0);
    check("t4_addr_r1", imem_addr, 32'h400);
    wait_valid(20);
    check("t4_first_pc", instr_pc, 32'h400);
    @(negedge clk);
    check("t4_second_pc", instr_pc, 32'h404);
    repeat (3) next_cycle();

    // --- redirect to the top of the address space: fetch PC wraps ----------
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    next_cycle();
    redirect = 1'b0;
    @(negedge clk);
    check("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    check("t5_addr_wrap_valid", {31'b0, imem_req_valid}, 32'd1);
    check("t5_addr_wrap", imem_addr, 32'h0);
    wait_valid(20);
    check("t5_pc_top", instr_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    check("t5_pc_wrap", instr_pc, 32'h0);
    check("t5_instr_wrap", instr, 32'h100);

    // --- reset with a full FIFO, then with discards pending -----------------
    next_cycle();
    instr_ready = 1'b0;
    repeat (10) next_cycle();
    check("t6_full_valid", {31'b0, instr_valid}, 32'd1);
    rst = 1'b0;
    #3;
    check("t6_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("t6_rst_addr", imem_addr, RESET_PC);
    check("t6_rst_valid", {31'b0, instr_valid}, 32'd0);
    check("t6_rst_instr", instr, 32'd0);
    check("t6_rst_pc", instr_pc, 32'd0);
    instr_ready = 1'b1;
    mem_lat     = 5;
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("t6_restart_addr", imem_addr, RESET_PC);
    next_cycle();
    next_cycle();
    redirect    = 1'b1;
    redirect_pc = 32'h80;
    next_cycle();
    redirect = 1'b0;
    rst      = 1'b0;
    #3;
    check("t6b_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("t6b_rst_addr", imem_addr, RESET_PC);
    check("t6b_rst_valid", {31'b0, instr_valid}, 32'd0);
    mem_lat = 1;
    repeat (2) next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("t6b_restart_valid", {31'b0, imem_req_valid}, 32'd1);
    check("t6b_restart_addr", imem_addr, RESET_PC);
    wait_valid(20);
    check("t6b_first_pc", instr_pc, RESET_PC);
    check("t6b_first_instr", instr, RESET_PC + DATA_OFS);
    repeat (5) next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got still running expected finished");
    $fatal(1);
  end

endmodule
